// File: rtl/gb_rd_bank_arbiter.sv
// gb_rd_bank_arbiter: round-robin sharing of the global-buffer bank read ports among three read controllers
module gb_rd_bank_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 96,
    parameter int NUM_BANK   = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start_i,
    input  logic [2:0]                     req_i,
    input  logic [17:0]                    req_id_i,
    input  logic [3*ADDR_WIDTH-1:0]        req_addr_i,
    output logic [2:0]                     gnt_o,
    output logic [NUM_BANK-1:0]            bank_rd_en_o,
    output logic [NUM_BANK*ADDR_WIDTH-1:0] bank_rd_addr_o,
    input  logic [NUM_BANK*DATA_WIDTH-1:0] bank_rd_data_i,
    output logic [2:0]                     rsp_val_o,
    output logic [3*DATA_WIDTH-1:0]        rsp_data_o,
    output logic                           err_bank_o,
    output logic [15:0]                    conflict_cnt_o
);
    logic [5:0] id [3];
    logic [2:0] legal, coll, sel;
    logic [1:0] win, rr_q, rr_d;
    logic err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [NUM_BANK-1:0] en_q, en_d;
    logic [NUM_BANK*ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RD_LAT:0] tv_q [3];
    logic [5:0] tid_q [3][RD_LAT+1];

    // Decode bank IDs, their legality, and which legal requesters share a bank
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            id[r] = req_id_i[6*r +: 6];
            legal[r] = req_i[r] && (32'(id[r]) < NUM_BANK);
        end
        for (int r = 0; r < 3; r++) begin
            coll[r] = 1'b0;
            for (int s = 0; s < 3; s++)
                if (s != r && legal[s] && id[s] == id[r]) coll[r] = legal[r];
        end
    end

    // Collision winner is the first colliding requester scanning from rr_q; everyone else legal and alone is granted
    always_comb begin
        win = 2'd0;
        sel = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            sel = 3'(rr_q) + 3'(k);
            sel = (sel >= 3'd3) ? sel - 3'd3 : sel;
            if (coll[sel[1:0]]) win = sel[1:0];
        end
        for (int r = 0; r < 3; r++)
            gnt_o[r] = legal[r] && (!coll[r] || win == 2'(r));
    end

    // Steer each grant onto its bank's read port for the following cycle; idle banks keep their last address
    always_comb begin
        en_d = '0;
        addr_d = addr_q;
        for (int b = 0; b < NUM_BANK; b++)
            for (int r = 0; r < 3; r++)
                if (gnt_o[r] && id[r] == 6'(b)) begin
                    en_d[b] = 1'b1;
                    addr_d[b*ADDR_WIDTH +: ADDR_WIDTH] = req_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
                end
    end

    // Round-robin pointer, sticky error and collision counter; a layer start clears them ahead of any update
    always_comb begin
        rr_d = cfg_start_i ? 2'd0 : (|coll) ? ((win == 2'd2) ? 2'd0 : win + 2'd1) : rr_q;
        err_d = !cfg_start_i && (err_q || (|(req_i & ~legal)));
        cnt_d = cfg_start_i ? 16'd0 : ((|coll) && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    // Arbiter state and registered bank read ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 2'd0;
            err_q <= 1'b0;
            cnt_q <= 16'd0;
            en_q <= '0;
            addr_q <= '0;
        end else begin
            rr_q <= rr_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            en_q <= en_d;
            addr_q <= addr_d;
        end
    end

    // Per-requester {valid, bank} tags ride alongside the bank latency so data can be routed home
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                tv_q[r] <= '0;
                for (int k = 0; k <= RD_LAT; k++) tid_q[r][k] <= 6'd0;
            end
        end else begin
            for (int r = 0; r < 3; r++) begin
                tv_q[r] <= {tv_q[r][RD_LAT-1:0], gnt_o[r]};
                tid_q[r][0] <= id[r];
                for (int k = 1; k <= RD_LAT; k++) tid_q[r][k] <= tid_q[r][k-1];
            end
        end
    end

    // Return mux: the oldest tag selects which bank's data each requester sees
    always_comb begin
        rsp_data_o = '0;
        for (int r = 0; r < 3; r++) begin
            rsp_val_o[r] = tv_q[r][RD_LAT];
            for (int b = 0; b < NUM_BANK; b++)
                if (tv_q[r][RD_LAT] && tid_q[r][RD_LAT] == 6'(b))
                    rsp_data_o[r*DATA_WIDTH +: DATA_WIDTH] = bank_rd_data_i[b*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bank_rd_en_o = en_q;
    assign bank_rd_addr_o = addr_q;
    assign err_bank_o = err_q;
    assign conflict_cnt_o = cnt_q;
endmodule
